// File: rtl/decode_family_stage.sv
// Registered ARMv4 instruction-family decode stage with 2-entry skid buffer and undef counter.
// Optional `DECODE_COND_EN: evaluate out_ir[31:28] against live cpsr_nzcv (otherwise out_cond_pass=1).
module decode_family_stage #(
    parameter  int EXT_FAMILIES = 1,
    parameter  int CNT_W        = 16,
    localparam int FW           = (EXT_FAMILIES != 0) ? 21 : 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [31:0]      in_pc,
    input  logic [3:0]       cpsr_nzcv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ir,
    output logic [31:0]      out_pc,
    output logic [FW-1:0]    out_fam,
    output logic             out_undef,
    output logic             out_cond_pass,
    output logic [CNT_W-1:0] undef_count
);

    // Returns {hit, family index}; hit=0 means no supported family.
    function automatic logic [5:0] decode_idx(input logic [31:0] ir);
        logic       hit;
        logic [4:0] idx;
        hit = 1'b1;
        idx = 5'd0;
        case (ir[27:25])
            3'b000: begin
                if (EXT_FAMILIES != 0 && ir[27:4] == 24'h12FFF1)           idx = 5'd20;
                else if (ir[24:22] == 3'b000 && ir[7:4] == 4'b1001)         idx = 5'd3;
                else if (ir[24:23] == 2'b01 && ir[7:4] == 4'b1001)          idx = 5'd4;
                else if (ir[24:23] == 2'b10 && ir[21:20] == 2'b00)
                    idx = (ir[7:4] == 4'b1001) ? 5'd12 : 5'd5;
                else if (ir[24:23] == 2'b10 && ir[21:20] == 2'b10 && !ir[4]) idx = 5'd7;
                else if (!ir[4])                                            idx = 5'd1;
                else if (!ir[7])                                            idx = 5'd2;
                else                                                        idx = ir[22] ? 5'd10 : 5'd11;
            end
            3'b001: idx = (ir[24:23] == 2'b10 && ir[21:20] == 2'b10) ? 5'd6 : 5'd0;
            3'b010: idx = 5'd8;
            3'b011: idx = ir[4] ? 5'd15 : 5'd9;
            3'b100: idx = 5'd13;
            3'b101: idx = 5'd14;
            3'b110: begin
                hit = (EXT_FAMILIES != 0);
                idx = 5'd16;
            end
            default: begin
                hit = (EXT_FAMILIES != 0);
                if (ir[24])      idx = 5'd19;
                else if (!ir[4]) idx = 5'd17;
                else             idx = 5'd18;
            end
        endcase
        return {hit, idx};
    endfunction

    logic [5:0]       dec_w;
    logic [FW-1:0]    in_fam_w;
    logic             accept_w, release_w;

    logic             head_valid_q, head_valid_d;
    logic [31:0]      head_ir_q, head_ir_d, head_pc_q, head_pc_d;
    logic [FW-1:0]    head_fam_q, head_fam_d;
    logic             skid_valid_q, skid_valid_d;
    logic [31:0]      skid_ir_q, skid_ir_d, skid_pc_q, skid_pc_d;
    logic [FW-1:0]    skid_fam_q, skid_fam_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        dec_w = decode_idx(in_ir);
        for (int i = 0; i < FW; i++) begin
            in_fam_w[i] = dec_w[5] && (dec_w[4:0] == 5'(i));
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = head_valid_q;
    assign out_ir      = head_ir_q;
    assign out_pc      = head_pc_q;
    assign out_fam     = head_fam_q;
    assign out_undef   = head_valid_q & (head_fam_q[15] | ~|head_fam_q);
    assign undef_count = cnt_q;
    assign accept_w    = in_valid & in_ready;
    assign release_w   = head_valid_q & out_ready;

`ifdef DECODE_COND_EN
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c & !z;
            4'h9:    return !c | z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z & (n == v);
            4'hD:    return z | (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign out_cond_pass = cond_pass(head_ir_q[31:28], cpsr_nzcv);
`else
    logic unused_nzcv;
    assign unused_nzcv   = ^cpsr_nzcv;
    assign out_cond_pass = 1'b1;
`endif

    // Head refills from the skid first so FIFO order is preserved.
    always_comb begin
        head_valid_d = head_valid_q;
        head_ir_d    = head_ir_q;
        head_pc_d    = head_pc_q;
        head_fam_d   = head_fam_q;
        skid_valid_d = skid_valid_q;
        skid_ir_d    = skid_ir_q;
        skid_pc_d    = skid_pc_q;
        skid_fam_d   = skid_fam_q;
        cnt_d        = cnt_q;
        if (release_w && out_undef && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q || release_w) begin
            if (skid_valid_q) begin
                head_valid_d = 1'b1;
                head_ir_d    = skid_ir_q;
                head_pc_d    = skid_pc_q;
                head_fam_d   = skid_fam_q;
                skid_valid_d = 1'b0;
            end else if (accept_w) begin
                head_valid_d = 1'b1;
                head_ir_d    = in_ir;
                head_pc_d    = in_pc;
                head_fam_d   = in_fam_w;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept_w) begin
            skid_valid_d = 1'b1;
            skid_ir_d    = in_ir;
            skid_pc_d    = in_pc;
            skid_fam_d   = in_fam_w;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            head_ir_q    <= '0;
            head_pc_q    <= '0;
            head_fam_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ir_q    <= '0;
            skid_pc_q    <= '0;
            skid_fam_q   <= '0;
            cnt_q        <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_ir_q    <= head_ir_d;
            head_pc_q    <= head_pc_d;
            head_fam_q   <= head_fam_d;
            skid_valid_q <= skid_valid_d;
            skid_ir_q    <= skid_ir_d;
            skid_pc_q    <= skid_pc_d;
            skid_fam_q   <= skid_fam_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
